pa_core_lsu_ctrl: RTL and testbench

Load/store sequencer between the execute stage and the system bus master port. It accepts one memory request at a time, checks alignment, and drives the bus request/acknowledge handshake with arbitrary wait states. It produces the two-stage phase bit for the memory access unit (phase 0 = issue, phase 1 = load response), stalls the pipeline for the duration of the access, and reports misalignment and bus errors.

---
 rtl/pa_chip_param.sv | 44 ++++
 rtl/pa_core_lsu_wdt.sv | 31 +++
 rtl/pa_core_lsu_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pa_core_lsu_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_chip_param.sv
// pa_chip_param: shared encodings for the load/store controller.
// Contents: FSM state encodings (3 bits), access size encodings,
// error-cause encoding, default watchdog limit, alignment helper.
package pa_chip_param;

  localparam int unsigned STATE_W            = 3;
  localparam int unsigned SIZE_W             = 2;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned WDT_W              = 10;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RESP = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } lsu_state_e;

  typedef enum logic [SIZE_W-1:0] {
    SZ_WORD = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10
  } lsu_size_e;

  typedef enum logic {
    CAUSE_MISALIGN = 1'b0,
    CAUSE_BUS      = 1'b1
  } lsu_cause_e;

  // Size 11 has no legal meaning and is reported as misaligned.
  function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                         input logic [1:0]        addr_lo);
    logic mis;
    case (size)
      SZ_WORD: mis = (addr_lo != 2'b00);
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/pa_core_lsu_wdt.sv
// pa_core_lsu_wdt: bus-request watchdog counter.
// Ports: clk_i, rst_i (sync, active-high), clear_i (zero the count),
// enable_i (count this cycle), limit_i (cycles allowed),
// expired_o (this enabled cycle is the limit-th one).
module pa_core_lsu_wdt
  import pa_chip_param::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WDT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [WDT_W-1:0] count_q;

  // Count holds the number of enabled cycles already elapsed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + WDT_W'(1);
    end
  end

  assign expired_o = enable_i && (count_q == (limit_i - WDT_W'(1)));

endmodule

// File: rtl/pa_core_lsu_ctrl.sv
// pa_core_lsu_ctrl: load/store sequencer between execute and the bus master.
// Accepts one request at a time, checks alignment, runs the req/ack
// handshake with wait states, and reports done/misalign/bus-error pulses.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   lsu_vld_i/lsu_load_i/lsu_store_i/lsu_size_i/lsu_addr_i, flush_i : request side
//   lsu_stall_o, lsu_phase_o, lsu_done_o, lsu_rdata_o,
//   lsu_misalign_o, lsu_buserr_o                                  : pipeline side
//   bus_req_o, bus_we_o, bus_addr_o, bus_ack_i, bus_err_i, bus_rdata_i : bus side
// Build option: PA_LSU_TIMEOUT_EN compiles in the REQ watchdog.
module pa_core_lsu_ctrl
  import pa_chip_param::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lsu_vld_i,
  input  logic                  lsu_load_i,
  input  logic                  lsu_store_i,
  input  logic [SIZE_W-1:0]     lsu_size_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic                  flush_i,
  output logic                  lsu_stall_o,
  output logic                  lsu_phase_o,
  output logic                  lsu_done_o,
  output logic [DATA_W-1:0]     lsu_rdata_o,
  output logic                  lsu_misalign_o,
  output logic                  lsu_buserr_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  input  logic                  bus_ack_i,
  input  logic                  bus_err_i,
  input  logic [DATA_W-1:0]     bus_rdata_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("pa_core_lsu_ctrl: TIMEOUT_CYCLES must be in 1..1023");
  end

  lsu_state_e            state_q, state_d;
  lsu_cause_e            cause_q;
  logic                  kill_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_W-1:0]     rdata_q;

  logic accept_c;
  logic misalign_c;
  logic wdt_expired;

  // Exactly one of load/store, and never during a flush.
  assign accept_c   = (state_q == ST_IDLE) && lsu_vld_i &&
                      (lsu_load_i ^ lsu_store_i) && !flush_i;
  assign misalign_c = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);

`ifdef PA_LSU_TIMEOUT_EN
  // Held clear outside REQ, so every REQ entry starts from zero.
  pa_core_lsu_wdt u_wdt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q != ST_REQ),
    .enable_i  (state_q == ST_REQ),
    .limit_i   (WDT_W'(TIMEOUT_CYCLES)),
    .expired_o (wdt_expired)
  );
`else
  assign wdt_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; bus error wins over a simultaneous ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = misalign_c ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_err_i) begin
          state_d = ST_ERR;
        end else if (bus_ack_i) begin
          state_d = we_q ? ST_DONE : ST_RESP;
        end else if (wdt_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_RESP, ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output decode; a killed access completes on the bus but stays silent.
  always_comb begin
    lsu_stall_o    = 1'b0;
    lsu_phase_o    = 1'b0;
    lsu_done_o     = 1'b0;
    lsu_misalign_o = 1'b0;
    lsu_buserr_o   = 1'b0;
    bus_req_o      = 1'b0;
    case (state_q)
      ST_IDLE: lsu_stall_o = accept_c;
      ST_REQ: begin
        lsu_stall_o = 1'b1;
        bus_req_o   = 1'b1;
      end
      ST_RESP: begin
        lsu_phase_o = 1'b1;
        lsu_done_o  = !kill_q;
      end
      ST_DONE: lsu_done_o = !kill_q;
      ST_ERR: begin
        lsu_done_o     = !kill_q;
        lsu_misalign_o = (cause_q == CAUSE_MISALIGN);
        lsu_buserr_o   = (cause_q == CAUSE_BUS) && !kill_q;
      end
      default: ;
    endcase
  end

  // Request latch, error cause, load data capture and flush kill flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      cause_q <= CAUSE_MISALIGN;
      rdata_q <= '0;
      kill_q  <= 1'b0;
    end else begin
      if (accept_c) begin
        addr_q <= lsu_addr_i;
        we_q   <= lsu_store_i;
      end
      if (state_d == ST_ERR) begin
        cause_q <= (state_q == ST_IDLE) ? CAUSE_MISALIGN : CAUSE_BUS;
      end
      // A flush in the ack cycle itself also blocks the capture.
      if ((state_q == ST_REQ) && bus_ack_i && !bus_err_i && !we_q &&
          !kill_q && !flush_i) begin
        rdata_q <= bus_rdata_i;
      end
      if (state_d == ST_IDLE) begin
        kill_q <= 1'b0;
      end else if ((state_q == ST_REQ) && flush_i) begin
        kill_q <= 1'b1;
      end
    end
  end

  assign bus_addr_o  = addr_q;
  assign bus_we_o    = we_q;
  assign lsu_rdata_o = rdata_q;

endmodule

// File: tb/tb_pa_core_lsu_ctrl.sv
// tb_pa_core_lsu_ctrl: directed bench for pa_core_lsu_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled 1-2ns later.
module tb_pa_core_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_vld_i, lsu_load_i, lsu_store_i, flush_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic        lsu_stall_o, lsu_phase_o, lsu_done_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_misalign_o, lsu_buserr_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;
  int nreq;

  pa_core_lsu_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lsu_vld_i      (lsu_vld_i),
    .lsu_load_i     (lsu_load_i),
    .lsu_store_i    (lsu_store_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_addr_i     (lsu_addr_i),
    .flush_i        (flush_i),
    .lsu_stall_o    (lsu_stall_o),
    .lsu_phase_o    (lsu_phase_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_misalign_o (lsu_misalign_o),
    .lsu_buserr_o   (lsu_buserr_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_ack_i      (bus_ack_i),
    .bus_err_i      (bus_err_i),
    .bus_rdata_i    (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    lsu_vld_i   = 1'b0;
    lsu_load_i  = 1'b0;
    lsu_store_i = 1'b0;
    lsu_size_i  = 2'b00;
    lsu_addr_i  = 32'h0;
    flush_i     = 1'b0;
    bus_ack_i   = 1'b0;
    bus_err_i   = 1'b0;
    bus_rdata_i = 32'h0;
  endtask

  task automatic drive_req(input logic ld, input logic st, input logic [1:0] sz,
                           input logic [31:0] a);
    lsu_vld_i   = 1'b1;
    lsu_load_i  = ld;
    lsu_store_i = st;
    lsu_size_i  = sz;
    lsu_addr_i  = a;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_in();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rst_stall",    32'(lsu_stall_o), 32'd0);
    check("rst_phase",    32'(lsu_phase_o), 32'd0);
    check("rst_done",     32'(lsu_done_o), 32'd0);
    check("rst_rdata",    lsu_rdata_o, 32'h0);
    check("rst_misalign", 32'(lsu_misalign_o), 32'd0);
    check("rst_buserr",   32'(lsu_buserr_o), 32'd0);
    check("rst_req",      32'(bus_req_o), 32'd0);
    check("rst_we",       32'(bus_we_o), 32'd0);
    check("rst_addr",     bus_addr_o, 32'h0);

    // Store word to 0x1000, two wait states.
    drive_req(1'b0, 1'b1, 2'b00, 32'h1000);
    #1;
    check("st_acc_stall", 32'(lsu_stall_o), 32'd1);
    check("st_acc_noreq", 32'(bus_req_o), 32'd0);
    step();
    clr_in();
    nreq = 0;
    for (int i = 0; i < 3; i++) begin
      bus_ack_i = (i == 2);
      #1;
      if (bus_req_o) nreq++;
      check("st_req_stall", 32'(lsu_stall_o), 32'd1);
      check("st_req_phase", 32'(lsu_phase_o), 32'd0);
      check("st_we",        32'(bus_we_o), 32'd1);
      check("st_addr",      bus_addr_o, 32'h1000);
      step();
    end
    clr_in();
    #1;
    check("st_req_cycles", 32'(nreq), 32'd3);
    check("st_done",       32'(lsu_done_o), 32'd1);
    check("st_done_phase", 32'(lsu_phase_o), 32'd0);
    check("st_done_stall", 32'(lsu_stall_o), 32'd0);
    check("st_done_noreq", 32'(bus_req_o), 32'd0);
    step();
    check("st_done_gone",  32'(lsu_done_o), 32'd0);

    // Load byte from 0x2003, zero wait states.
    drive_req(1'b1, 1'b0, 2'b01, 32'h2003);
    #1;
    check("ld_acc_stall", 32'(lsu_stall_o), 32'd1);
    step();
    clr_in();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hA5B6C7D8;
    #1;
    check("ld_req",  32'(bus_req_o), 32'd1);
    check("ld_we",   32'(bus_we_o), 32'd0);
    check("ld_addr", bus_addr_o, 32'h2003);
    step();
    clr_in();
    #1;
    check("ld_phase", 32'(lsu_phase_o), 32'd1);
    check("ld_done",  32'(lsu_done_o), 32'd1);
    check("ld_rdata", lsu_rdata_o, 32'hA5B6C7D8);
    check("ld_stall", 32'(lsu_stall_o), 32'd0);
    step();
    check("ld_phase_clr", 32'(lsu_phase_o), 32'd0);
    check("ld_rdata_hold", lsu_rdata_o, 32'hA5B6C7D8);

    // Misaligned half load at 0x2001.
    drive_req(1'b1, 1'b0, 2'b10, 32'h2001);
    #1;
    check("mis_acc_stall", 32'(lsu_stall_o), 32'd1);
    check("mis_acc_noreq", 32'(bus_req_o), 32'd0);
    step();
    clr_in();
    #1;
    check("mis_flag",   32'(lsu_misalign_o), 32'd1);
    check("mis_done",   32'(lsu_done_o), 32'd1);
    check("mis_noreq",  32'(bus_req_o), 32'd0);
    check("mis_stall",  32'(lsu_stall_o), 32'd0);
    check("mis_buserr", 32'(lsu_buserr_o), 32'd0);
    step();
    check("mis_clr", 32'(lsu_misalign_o), 32'd0);

    // Word at 0x1002 and size 11 are both misaligned.
    drive_req(1'b0, 1'b1, 2'b00, 32'h1002);
    step();
    clr_in();
    #1;
    check("mis_word", 32'(lsu_misalign_o), 32'd1);
    step();
    drive_req(1'b0, 1'b1, 2'b11, 32'h0);
    step();
    clr_in();
    #1;
    check("mis_size11", 32'(lsu_misalign_o), 32'd1);
    step();

    // Both load and store set: ignored. Flush in accept cycle: ignored.
    drive_req(1'b1, 1'b1, 2'b00, 32'h10);
    #1;
    check("both_nostall", 32'(lsu_stall_o), 32'd0);
    step();
    clr_in();
    #1;
    check("both_noreq", 32'(bus_req_o), 32'd0);
    drive_req(1'b1, 1'b0, 2'b00, 32'h10);
    flush_i = 1'b1;
    #1;
    check("flacc_nostall", 32'(lsu_stall_o), 32'd0);
    step();
    clr_in();
    #1;
    check("flacc_noreq", 32'(bus_req_o), 32'd0);

    // Load word, flush during REQ, ack three cycles later.
    drive_req(1'b1, 1'b0, 2'b00, 32'h3000);
    step();
    clr_in();
    flush_i = 1'b1;
    #1;
    check("fl_req", 32'(bus_req_o), 32'd1);
    step();
    clr_in();
    step();
    step();
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h11112222;
    #1;
    check("fl_req_held", 32'(bus_req_o), 32'd1);
    step();
    clr_in();
    #1;
    check("fl_nodone",  32'(lsu_done_o), 32'd0);
    check("fl_rdata",   lsu_rdata_o, 32'hA5B6C7D8);
    check("fl_noreq",   32'(bus_req_o), 32'd0);
    step();
    drive_req(1'b0, 1'b1, 2'b00, 32'h40);
    #1;
    check("b2b_stall", 32'(lsu_stall_o), 32'd1);
    step();
    clr_in();
    bus_ack_i = 1'b1;
    #1;
    check("b2b_addr", bus_addr_o, 32'h40);
    step();
    clr_in();
    #1;
    check("b2b_done", 32'(lsu_done_o), 32'd1);
    step();

    // Simultaneous err and ack on a load.
    drive_req(1'b1, 1'b0, 2'b00, 32'h4000);
    step();
    clr_in();
    bus_ack_i   = 1'b1;
    bus_err_i   = 1'b1;
    bus_rdata_i = 32'hDEADBEEF;
    step();
    clr_in();
    #1;
    check("err_buserr", 32'(lsu_buserr_o), 32'd1);
    check("err_done",   32'(lsu_done_o), 32'd1);
    check("err_nomis",  32'(lsu_misalign_o), 32'd0);
    check("err_phase",  32'(lsu_phase_o), 32'd0);
    check("err_rdata",  lsu_rdata_o, 32'hA5B6C7D8);
    step();
    check("err_clr", 32'(lsu_buserr_o), 32'd0);

`ifdef PA_LSU_TIMEOUT_EN
    // Watchdog: no ack, limit 4.
    drive_req(1'b1, 1'b0, 2'b00, 32'h5000);
    step();
    clr_in();
    nreq = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus_req_o) nreq++;
      step();
    end
    #1;
    check("to_req_cycles", 32'(nreq), 32'd4);
    check("to_buserr",     32'(lsu_buserr_o), 32'd1);
    check("to_noreq",      32'(bus_req_o), 32'd0);
    step();
    bus_ack_i = 1'b1;
    step();
    clr_in();
    #1;
    check("to_late_ack", 32'(lsu_done_o), 32'd0);
`endif

    // Reset asserted while in REQ.
    drive_req(1'b0, 1'b1, 2'b00, 32'h5000);
    step();
    clr_in();
    #1;
    check("rr_req", 32'(bus_req_o), 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("rr_noreq",   32'(bus_req_o), 32'd0);
    check("rr_nostall", 32'(lsu_stall_o), 32'd0);
    check("rr_rdata",   lsu_rdata_o, 32'h0);
    drive_req(1'b0, 1'b1, 2'b00, 32'h6000);
    #1;
    check("rr_acc_stall", 32'(lsu_stall_o), 32'd1);
    step();
    clr_in();
    bus_ack_i = 1'b1;
    #1;
    check("rr_new_req",  32'(bus_req_o), 32'd1);
    check("rr_new_addr", bus_addr_o, 32'h6000);
    check("rr_new_we",   32'(bus_we_o), 32'd1);
    step();
    clr_in();
    #1;
    check("rr_new_done", 32'(lsu_done_o), 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
